pet_stat_scheduler: RTL and testbench

//  Sequences all updates to the four pet stat registers (food, sleep, fun, happy).

---
 rtl/pet_pkg.sv | 25 ++
 rtl/pet_sec_timer.sv | 26 ++
 rtl/pet_stat_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_pet_stat_scheduler.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pet_pkg.sv
// Shared stat indices, value limits, FSM encoding and grant record for the pet stat scheduler.
package pet_pkg;

  localparam logic [1:0] STAT_FOOD  = 2'd0;
  localparam logic [1:0] STAT_SLEEP = 2'd1;
  localparam logic [1:0] STAT_FUN   = 2'd2;
  localparam logic [1:0] STAT_HAPPY = 2'd3;

  localparam logic [2:0] STAT_MAX = 3'd7;
  localparam logic [2:0] STAT_MIN = 3'd0;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GRANT = 2'b01;
  localparam logic [1:0] HOLD  = 2'b10;

  typedef struct packed {
    logic [1:0] idx;
    logic       down;
  } pick_t;

  function automatic logic [3:0] stat_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/pet_sec_timer.sv
// Prescaler producing a one-cycle sec_tick in the wrap cycle of a 0..CLK_PER_SEC-1 count.
module pet_sec_timer #(
  parameter int CLK_PER_SEC = 50
) (
  input  logic clk,
  input  logic rst,
  output logic sec_tick
);

  localparam int CW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

  logic [CW-1:0] cnt;

  assign sec_tick = (cnt == CW'(CLK_PER_SEC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (sec_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pet_stat_scheduler.sv
// Round-robin scheduler issuing single up/down strobes to the four pet stat registers.
// Optional HEALTH_DECAY_EN adds per-stat zero timers driving health_down.
module pet_stat_scheduler
  import pet_pkg::*;
#(
  parameter int CLK_PER_SEC = 50,
  parameter int DECAY_FOOD  = 30,
  parameter int DECAY_SLEEP = 31,
  parameter int DECAY_FUN   = 25,
  parameter int HAPPY_SEC   = 20,
  parameter int COOLDOWN    = 4
`ifdef HEALTH_DECAY_EN
  , parameter int HEALTH_SEC = 10
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_feed,
  input  logic       btn_sleep,
  input  logic       btn_play,
  input  logic [2:0] food_value,
  input  logic [2:0] sleep_value,
  input  logic [2:0] fun_value,
  input  logic [2:0] happy_value,
  output logic [3:0] up_stb,
  output logic [3:0] down_stb,
  output logic       busy,
  output logic       sec_tick,
  output logic       health_down
);

  localparam int LIM [4] = '{DECAY_FOOD, DECAY_SLEEP, DECAY_FUN, HAPPY_SEC};

  logic [2:0] vals [4];
  logic [7:0] tmr [4];
  logic [3:0] tmr_hit;
  logic       happy_up, happy_dn;
  logic [3:0] up_set, down_set, up_clr, down_clr;
  logic [3:0] up_pend, down_pend, conflict, req;
  logic [1:0] state, ptr;
  logic [3:0] cd;
  pick_t      pick, sel;
  logic       pick_vld, take, blocked;
  logic [2:0] cur_val;

  assign vals[STAT_FOOD]  = food_value;
  assign vals[STAT_SLEEP] = sleep_value;
  assign vals[STAT_FUN]   = fun_value;
  assign vals[STAT_HAPPY] = happy_value;

  pet_sec_timer #(.CLK_PER_SEC(CLK_PER_SEC)) u_sec_timer (
    .clk      (clk),
    .rst      (rst),
    .sec_tick (sec_tick)
  );

  // Slots 0..2 are decay timers, slot 3 paces happiness evaluation.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      tmr_hit[k] = sec_tick && (tmr[k] == 8'(LIM[k] - 1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) tmr[k] <= '0;
    end else if (sec_tick) begin
      for (int k = 0; k < 4; k++) tmr[k] <= tmr_hit[k] ? 8'd0 : tmr[k] + 8'd1;
    end
  end

  assign happy_up = tmr_hit[3] && (food_value >= 3'd4) && (fun_value >= 3'd4);
  assign happy_dn = tmr_hit[3] && ((food_value <= 3'd2) || (fun_value <= 3'd2));

  assign up_set   = {happy_up, btn_play, btn_sleep, btn_feed};
  assign down_set = {happy_dn, tmr_hit[2:0]};

  // Opposing requests on one stat cancel each other without consuming a slot.
  assign conflict = up_pend & down_pend;
  assign req      = (up_pend | down_pend) & ~conflict;

  always_comb begin
    logic [1:0] idx;
    idx      = '0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!pick_vld && req[idx]) begin
        pick_vld  = 1'b1;
        pick.idx  = idx;
        pick.down = down_pend[idx];
      end
    end
  end

  assign take     = (state == IDLE) && pick_vld;
  assign up_clr   = conflict | ((take && !pick.down) ? stat_onehot(pick.idx) : 4'b0);
  assign down_clr = conflict | ((take &&  pick.down) ? stat_onehot(pick.idx) : 4'b0);

  // New requests arriving with a clear keep their pend bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_pend   <= '0;
      down_pend <= '0;
    end else begin
      up_pend   <= (up_pend   & ~up_clr)   | up_set;
      down_pend <= (down_pend & ~down_clr) | down_set;
    end
  end

  assign cur_val = vals[sel.idx];
  assign blocked = sel.down ? (cur_val == STAT_MIN) : (cur_val == STAT_MAX);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      sel      <= '0;
      cd       <= '0;
      up_stb   <= '0;
      down_stb <= '0;
    end else begin
      up_stb   <= '0;
      down_stb <= '0;
      case (state)
        IDLE: begin
          if (take) begin
            state <= GRANT;
            sel   <= pick;
            ptr   <= pick.idx + 2'd1;
          end
        end
        GRANT: begin
          if (blocked) begin
            state <= IDLE;
          end else begin
            state <= HOLD;
            cd    <= 4'(COOLDOWN);
            if (sel.down) down_stb <= stat_onehot(sel.idx);
            else          up_stb   <= stat_onehot(sel.idx);
          end
        end
        HOLD: begin
          if (cd == 4'd0) state <= IDLE;
          else            cd    <= cd - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HEALTH_DECAY_EN
  logic [7:0] ztmr [4];
  logic [3:0] zhit;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      zhit[k] = sec_tick && (vals[k] == STAT_MIN) && (ztmr[k] == 8'(HEALTH_SEC - 1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) ztmr[k] <= '0;
      health_down <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (vals[k] != STAT_MIN) ztmr[k] <= '0;
        else if (sec_tick)       ztmr[k] <= zhit[k] ? 8'd0 : ztmr[k] + 8'd1;
      end
      health_down <= |zhit;
    end
  end
`else
  assign health_down = 1'b0;
`endif

endmodule

// File: tb/tb_pet_stat_scheduler.sv
// Directed bench for pet_stat_scheduler with hand-computed cycle positions (CLK_PER_SEC=50, COOLDOWN=4).
module tb_pet_stat_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_feed = 1'b0, btn_sleep = 1'b0, btn_play = 1'b0;
  logic [2:0] food_value = 3'd3, sleep_value = 3'd3, fun_value = 3'd3, happy_value = 3'd3;
  logic [3:0] up_stb, down_stb;
  logic       busy, sec_tick, health_down;

  pet_stat_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .btn_feed    (btn_feed),
    .btn_sleep   (btn_sleep),
    .btn_play    (btn_play),
    .food_value  (food_value),
    .sleep_value (sleep_value),
    .fun_value   (fun_value),
    .happy_value (happy_value),
    .up_stb      (up_stb),
    .down_stb    (down_stb),
    .busy        (busy),
    .sec_tick    (sec_tick),
    .health_down (health_down)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc, tick_n, busy_n, hd_n, stb_n, viol_total;
  int stb_cyc [8];
  logic [7:0] stb_val [8];
  int t30;
  logic seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    cyc = 0; tick_n = 0; busy_n = 0; hd_n = 0; stb_n = 0;
  endtask

  // One clock: sample #1 after the rising edge and accumulate observations.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    tick_n += int'(sec_tick);
    busy_n += int'(busy);
    hd_n   += int'(health_down);
    if (!$onehot0({up_stb, down_stb})) viol_total++;
    if ({down_stb, up_stb} != 8'h00 && stb_n < 8) begin
      stb_cyc[stb_n] = cyc;
      stb_val[stb_n] = {down_stb, up_stb};
      stb_n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    btn_feed = 1'b0; btn_sleep = 1'b0; btn_play = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    clear_mon();
  endtask

  task automatic pulse(input logic f, input logic s, input logic p);
    btn_feed = f; btn_sleep = s; btn_play = p;
    step();
    btn_feed = 1'b0; btn_sleep = 1'b0; btn_play = 1'b0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_ticks(input int n, input int bound);
    for (int i = 0; i < bound && tick_n < n; i++) step();
    check("tick_wait", tick_n, n);
  endtask

  initial begin
    viol_total = 0;
    t30 = 0;

    // Asynchronous reset while a strobe is high
    do_reset();
    food_value = 3'd3;
    pulse(1'b1, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = (up_stb == 4'b0001);
    end
    check("rst_strobe_seen", seen, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rst_up_stb", up_stb, 4'b0000);
    check("rst_down_stb", down_stb, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_tick_health", {sec_tick, health_down}, 2'b00);

    // Single feed: sampled at edge 1, strobe visible after edge 3, busy 6 cycles
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    run_to(14);
    check("feed_stb_count", stb_n, 1);
    check("feed_stb_val", stb_val[0], 8'h01);
    check("feed_stb_cyc", stb_cyc[0], 3);
    check("feed_busy_cycles", busy_n, 6);

    // Feed at food=7: dropped, one busy cycle, pending bit gone
    do_reset();
    food_value = 3'd7;
    pulse(1'b1, 1'b0, 1'b0);
    run_to(12);
    check("full_no_stb", stb_n, 0);
    check("full_busy_cycles", busy_n, 1);
    food_value = 3'd3;
    run_to(24);
    check("full_pend_cleared", stb_n, 0);

    // Feed + play together from ptr=0: food first, fun after cooldown + re-arbitration
    do_reset();
    food_value = 3'd3; fun_value = 3'd3;
    pulse(1'b1, 1'b0, 1'b1);
    run_to(20);
    check("rr_stb_count", stb_n, 2);
    check("rr_first_val", stb_val[0], 8'h01);
    check("rr_first_cyc", stb_cyc[0], 3);
    check("rr_second_val", stb_val[1], 8'h04);
    check("rr_second_cyc", stb_cyc[1], 10);

    // 30 s run: happy up at 20 s, fun down at 25 s, food down at 30 s
    do_reset();
    food_value = 3'd5; sleep_value = 3'd5; fun_value = 3'd5; happy_value = 3'd3;
    wait_ticks(30, 2000);
    t30 = cyc;
    check("tick30_cycle", t30, 1499);
    check("pre30_stb_count", stb_n, 2);
    check("happy_up_val", stb_val[0], 8'h08);
    check("fun_down_val", stb_val[1], 8'h40);
    run_to(t30 + 12);
    check("food_decay_count", stb_n, 3);
    check("food_decay_val", stb_val[2], 8'h10);
    check("food_decay_cyc", stb_cyc[2], t30 + 3);
    check("no_health_pulse", hd_n, 0);

    // Feed on the food-decay tick: opposing requests cancel
    do_reset();
    wait_ticks(30, 2000);
    btn_feed = 1'b1;
    stb_n = 0; busy_n = 0;
    step();
    btn_feed = 1'b0;
    run_to(cyc + 12);
    check("cancel_no_stb", stb_n, 0);
    check("cancel_no_busy", busy_n, 0);

`ifdef HEALTH_DECAY_EN
    // Sleep at 0 for 10 s gives exactly one health pulse
    do_reset();
    food_value = 3'd5; sleep_value = 3'd0; fun_value = 3'd5; happy_value = 3'd3;
    wait_ticks(11, 700);
    check("health_one_pulse", hd_n, 1);

    // Sleep restored at 9 s: timer clears, no pulse
    do_reset();
    sleep_value = 3'd0;
    wait_ticks(9, 600);
    sleep_value = 3'd1;
    wait_ticks(12, 300);
    check("health_cleared", hd_n, 0);
`endif

    check("onehot0_strobes", viol_total, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
